// File: rtl/dcache_model.sv
// Data-cache stand-in for the LSU fire interface: zero-initialised word memory,
// byte-lane stores, formatted loads and a 2-entry killable response buffer.
module dcache_model #(
    parameter int XLEN      = 64,
    parameter int LDQ_DEPTH = 8,
    parameter int LDQ_WIDTH = 3,
    parameter int STQ_WIDTH = 3,
    parameter int MEM_AW    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      fire_st_addr,
    input  logic [XLEN-1:0]      fire_st_data,
    input  logic [2:0]           fire_st_data_size,
    input  logic [STQ_WIDTH-1:0] fire_st_stq_tag,
    input  logic                 fire_st_valid,
    output logic                 fire_st_ready,
    input  logic [XLEN-1:0]      fire_ld_addr,
    input  logic [2:0]           fire_ld_data_size,
    input  logic [LDQ_WIDTH-1:0] fire_ld_ldq_tag,
    input  logic                 fire_ld_valid,
    output logic                 fire_ld_ready,
    input  logic [LDQ_DEPTH-1:0] fire_ld_kill,
    output logic [XLEN-1:0]      dcache_data,
    output logic [LDQ_WIDTH-1:0] dcache_ldq_tag,
    output logic                 dcache_valid,
    input  logic                 dcache_ready
);

    localparam int WORDS = 1 << MEM_AW;

    typedef struct packed {
        logic                 vld;
        logic [LDQ_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } rsp_t;

    logic [WORDS-1:0][XLEN-1:0] r_mem;
    rsp_t [1:0]                 r_buf;
    rsp_t [1:0]                 w_buf_nxt;
    rsp_t                       w_push_ent;

    logic              w_st_fire, w_ld_fire;
    logic [MEM_AW-1:0] w_st_idx, w_ld_idx;
    logic [2:0]        w_st_off, w_ld_off;
    logic [7:0]        w_st_mask;
    logic [XLEN-1:0]   w_st_wdata, w_ld_shift, w_ld_fmt;
    logic              w_pop, w_keep0, w_keep1, w_push;
    logic              w_unused_bits;

    assign w_unused_bits = ^{fire_st_stq_tag, fire_st_addr[XLEN-1:3+MEM_AW],
                             fire_ld_addr[XLEN-1:3+MEM_AW]};

    assign fire_st_ready = ~rst;
    assign fire_ld_ready = ~rst & ~(r_buf[0].vld & r_buf[1].vld);
    assign w_st_fire     = fire_st_valid & fire_st_ready;
    assign w_ld_fire     = fire_ld_valid & fire_ld_ready;

    // Store lanes: offset aligned down to the access size; illegal sizes write nothing.
    assign w_st_idx = fire_st_addr[3 +: MEM_AW];
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_st_off  = 3'd0;
        w_st_mask = 8'h00;
        case (fire_st_data_size)
            3'd0: begin w_st_off = fire_st_addr[2:0];          w_st_mask = 8'h01 << w_st_off; end
            3'd1: begin w_st_off = {fire_st_addr[2:1], 1'b0};  w_st_mask = 8'h03 << w_st_off; end
            3'd2: begin w_st_off = {fire_st_addr[2], 2'b00};   w_st_mask = 8'h0F << w_st_off; end
            3'd3: begin w_st_off = 3'd0;                       w_st_mask = 8'hFF;             end
            default: ;
        endcase
    end
    assign w_st_wdata = fire_st_data << {w_st_off, 3'b000};

    assign w_ld_idx   = fire_ld_addr[3 +: MEM_AW];
    always_comb begin
        w_ld_off = 3'd0;
        case (fire_ld_data_size[1:0])
            2'd0:    w_ld_off = fire_ld_addr[2:0];
            2'd1:    w_ld_off = {fire_ld_addr[2:1], 1'b0};
            2'd2:    w_ld_off = {fire_ld_addr[2], 2'b00};
            default: w_ld_off = 3'd0;
        endcase
    end
    // Loads read the pre-edge contents, so a same-cycle store is not visible.
    assign w_ld_shift = r_mem[w_ld_idx] >> {w_ld_off, 3'b000};

    always_comb begin
        w_ld_fmt = '0;
        case (fire_ld_data_size)
            3'd0: w_ld_fmt = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
            3'd1: w_ld_fmt = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'd2: w_ld_fmt = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
            3'd3: w_ld_fmt = w_ld_shift;
            3'd4: w_ld_fmt = {56'd0, w_ld_shift[7:0]};
            3'd5: w_ld_fmt = {48'd0, w_ld_shift[15:0]};
            3'd6: w_ld_fmt = {32'd0, w_ld_shift[31:0]};
            default: w_ld_fmt = '0;
        endcase
    end

    assign dcache_valid   = r_buf[0].vld & ~fire_ld_kill[r_buf[0].tag];
    assign dcache_data    = r_buf[0].data;
    assign dcache_ldq_tag = r_buf[0].tag;

    // Survivors keep age order and compact toward slot 0; the push goes behind them.
    assign w_pop   = dcache_valid & dcache_ready;
    assign w_keep0 = r_buf[0].vld & ~fire_ld_kill[r_buf[0].tag] & ~w_pop;
    assign w_keep1 = r_buf[1].vld & ~fire_ld_kill[r_buf[1].tag];
    assign w_push  = w_ld_fire & ~fire_ld_kill[fire_ld_ldq_tag];

    always_comb begin
        w_push_ent.vld  = 1'b1;
        w_push_ent.tag  = fire_ld_ldq_tag;
        w_push_ent.data = w_ld_fmt;
        w_buf_nxt       = '0;
        if (w_keep0) begin
            w_buf_nxt[0] = r_buf[0];
            if (w_keep1)     w_buf_nxt[1] = r_buf[1];
            else if (w_push) w_buf_nxt[1] = w_push_ent;
        end else if (w_keep1) begin
            w_buf_nxt[0] = r_buf[1];
            if (w_push) w_buf_nxt[1] = w_push_ent;
        end else if (w_push) begin
            w_buf_nxt[0] = w_push_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_buf <= '0;
        end else begin
            r_buf <= w_buf_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the memory is architecturally zero after reset, so it is cleared here.
            r_mem <= '0;
        end else if (w_st_fire) begin
            for (int b = 0; b < 8; b++) begin
                if (w_st_mask[b]) r_mem[w_st_idx][8*b +: 8] <= w_st_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_model.sv
// Directed self-checking bench for dcache_model: formatting, partial stores,
// backpressure, kill, streaming against a word model, and mid-run reset.
module tb_dcache_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] fire_st_addr = '0;
    logic [63:0] fire_st_data = '0;
    logic [2:0]  fire_st_data_size = '0;
    logic [2:0]  fire_st_stq_tag = '0;
    logic        fire_st_valid = 1'b0;
    logic        fire_st_ready;
    logic [63:0] fire_ld_addr = '0;
    logic [2:0]  fire_ld_data_size = '0;
    logic [2:0]  fire_ld_ldq_tag = '0;
    logic        fire_ld_valid = 1'b0;
    logic        fire_ld_ready;
    logic [7:0]  fire_ld_kill = '0;
    logic [63:0] dcache_data;
    logic [2:0]  dcache_ldq_tag;
    logic        dcache_valid;
    logic        dcache_ready = 1'b1;

    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] ref_mem [16];

    dcache_model dut (
        .clk               (clk),
        .rst               (rst),
        .fire_st_addr      (fire_st_addr),
        .fire_st_data      (fire_st_data),
        .fire_st_data_size (fire_st_data_size),
        .fire_st_stq_tag   (fire_st_stq_tag),
        .fire_st_valid     (fire_st_valid),
        .fire_st_ready     (fire_st_ready),
        .fire_ld_addr      (fire_ld_addr),
        .fire_ld_data_size (fire_ld_data_size),
        .fire_ld_ldq_tag   (fire_ld_ldq_tag),
        .fire_ld_valid     (fire_ld_valid),
        .fire_ld_ready     (fire_ld_ready),
        .fire_ld_kill      (fire_ld_kill),
        .dcache_data       (dcache_data),
        .dcache_ldq_tag    (dcache_ldq_tag),
        .dcache_valid      (dcache_valid),
        .dcache_ready      (dcache_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [63:0] addr, input logic [63:0] data, input logic [2:0] size);
        fire_st_addr      = addr;
        fire_st_data      = data;
        fire_st_data_size = size;
        fire_st_valid     = 1'b1;
        #1;
        check("st_ready", {63'd0, fire_st_ready}, 64'd1);
        tick();
        fire_st_valid = 1'b0;
    endtask

    task automatic set_load(input logic [63:0] addr, input logic [2:0] size, input logic [2:0] tag);
        fire_ld_addr      = addr;
        fire_ld_data_size = size;
        fire_ld_ldq_tag   = tag;
        fire_ld_valid     = 1'b1;
    endtask

    task automatic expect_rsp(input string name, input logic [2:0] tag, input logic [63:0] data);
        check({name, "_valid"}, {63'd0, dcache_valid}, 64'd1);
        check({name, "_tag"}, {61'd0, dcache_ldq_tag}, {61'd0, tag});
        check({name, "_data"}, dcache_data, data);
    endtask

    // Single load with dcache_ready high: accepted this cycle, response next cycle.
    task automatic load_check(input string name, input logic [63:0] addr, input logic [2:0] size,
                              input logic [2:0] tag, input logic [63:0] exp);
        dcache_ready = 1'b1;
        set_load(addr, size, tag);
        #1;
        check({name, "_ld_ready"}, {63'd0, fire_ld_ready}, 64'd1);
        tick();
        fire_ld_valid = 1'b0;
        #1;
        expect_rsp(name, tag, exp);
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_st_ready", {63'd0, fire_st_ready}, 64'd0);
        check("rst_ld_ready", {63'd0, fire_ld_ready}, 64'd0);
        check("rst_valid", {63'd0, dcache_valid}, 64'd0);
        check("rst_data", dcache_data, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("exit_st_ready", {63'd0, fire_st_ready}, 64'd1);
        check("exit_ld_ready", {63'd0, fire_ld_ready}, 64'd1);
        check("exit_valid", {63'd0, dcache_valid}, 64'd0);
        tick();

        // Formatting and aliasing
        store(64'h10, 64'h8000_0000_0000_00F0, 3'd3);
        load_check("lb",       64'h10,  3'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFF0);
        load_check("lbu",      64'h10,  3'd4, 3'd2, 64'h0000_0000_0000_00F0);
        load_check("ld_alias", 64'h210, 3'd3, 3'd7, 64'h8000_0000_0000_00F0);
        load_check("ld_sz7",   64'h10,  3'd7, 3'd1, 64'd0);

        // Partial store with a same-cycle load seeing the old word
        store(64'h8, 64'd0, 3'd3);
        fire_st_addr = 64'hA; fire_st_data = 64'hBEEF; fire_st_data_size = 3'd1; fire_st_valid = 1'b1;
        set_load(64'h8, 3'd3, 3'd0);
        tick();
        fire_st_valid = 1'b0;
        fire_ld_valid = 1'b0;
        #1;
        expect_rsp("same_cycle", 3'd0, 64'd0);
        tick();
        load_check("sh_ld",  64'h8, 3'd3, 3'd1, 64'h0000_0000_BEEF_0000);
        load_check("lh_mis", 64'hB, 3'd1, 3'd2, 64'hFFFF_FFFF_FFFF_BEEF);
        load_check("lhu",    64'hA, 3'd5, 3'd3, 64'h0000_0000_0000_BEEF);
        load_check("lw_hi",  64'hC, 3'd2, 3'd4, 64'd0);
        store(64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 3'd5);
        load_check("illegal_st", 64'h8, 3'd3, 3'd5, 64'h0000_0000_BEEF_0000);

        // Backpressure: tags 1,2 buffered, tag 3 waits
        dcache_ready = 1'b0;
        set_load(64'h10, 3'd3, 3'd1);
        #1;
        check("bp_rdy1", {63'd0, fire_ld_ready}, 64'd1);
        tick();
        set_load(64'h8, 3'd3, 3'd2);
        #1;
        check("bp_rdy2", {63'd0, fire_ld_ready}, 64'd1);
        expect_rsp("bp_head1", 3'd1, 64'h8000_0000_0000_00F0);
        tick();
        set_load(64'h0, 3'd3, 3'd3);
        #1;
        check("bp_full", {63'd0, fire_ld_ready}, 64'd0);
        tick();
        expect_rsp("bp_stable", 3'd1, 64'h8000_0000_0000_00F0);
        dcache_ready = 1'b1;
        #1;
        check("bp_no_comb", {63'd0, fire_ld_ready}, 64'd0);
        tick();
        expect_rsp("bp_out2", 3'd2, 64'h0000_0000_BEEF_0000);
        check("bp_slot_free", {63'd0, fire_ld_ready}, 64'd1);
        tick();
        fire_ld_valid = 1'b0;
        #1;
        expect_rsp("bp_out3", 3'd3, 64'd0);
        tick();
        check("bp_empty", {63'd0, dcache_valid}, 64'd0);

        // Kill a buffered head, then kill a load in its accept cycle
        dcache_ready = 1'b0;
        set_load(64'h10, 3'd4, 3'd4);
        tick();
        set_load(64'h8, 3'd3, 3'd5);
        tick();
        fire_ld_valid = 1'b0;
        fire_ld_kill = 8'h10;
        #1;
        check("kill_mask", {63'd0, dcache_valid}, 64'd0);
        tick();
        fire_ld_kill = 8'h00;
        #1;
        expect_rsp("kill_surv", 3'd5, 64'h0000_0000_BEEF_0000);
        dcache_ready = 1'b1;
        tick();
        check("kill_drained", {63'd0, dcache_valid}, 64'd0);
        set_load(64'h10, 3'd3, 3'd6);
        fire_ld_kill = 8'h40;
        #1;
        check("kill_acc_rdy", {63'd0, fire_ld_ready}, 64'd1);
        tick();
        fire_ld_valid = 1'b0;
        fire_ld_kill = 8'h00;
        #1;
        check("kill_acc_none", {63'd0, dcache_valid}, 64'd0);
        tick();
        check("kill_acc_none2", {63'd0, dcache_valid}, 64'd0);

        // Streaming against a word model
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = 64'h0123_4567_89AB_CDEF * 64'(k + 3);
            store(64'h80 + 64'(8 * k), ref_mem[k], 3'd3);
        end
        dcache_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_load(64'h80 + 64'(8 * (i % 16)), 3'd3, 3'(i % 8));
            #1;
            check("strm_ready", {63'd0, fire_ld_ready}, 64'd1);
            if (i > 0) expect_rsp("strm", 3'((i - 1) % 8), ref_mem[(i - 1) % 16]);
            tick();
        end
        fire_ld_valid = 1'b0;
        #1;
        expect_rsp("strm_last", 3'(99 % 8), ref_mem[99 % 16]);
        tick();

        // Asynchronous reset with two buffered responses
        dcache_ready = 1'b0;
        set_load(64'h80, 3'd3, 3'd1);
        tick();
        set_load(64'h88, 3'd3, 3'd2);
        tick();
        fire_ld_valid = 1'b0;
        #1;
        check("pre_rst_full", {63'd0, fire_ld_ready}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_st_ready", {63'd0, fire_st_ready}, 64'd0);
        check("mid_rst_ld_ready", {63'd0, fire_ld_ready}, 64'd0);
        check("mid_rst_valid", {63'd0, dcache_valid}, 64'd0);
        check("mid_rst_data", dcache_data, 64'd0);
        check("mid_rst_tag", {61'd0, dcache_ldq_tag}, 64'd0);
        tick();
        rst = 1'b0;
        dcache_ready = 1'b1;
        #1;
        check("post_rst_st_ready", {63'd0, fire_st_ready}, 64'd1);
        check("post_rst_ld_ready", {63'd0, fire_ld_ready}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            check("post_rst_quiet", {63'd0, dcache_valid}, 64'd0);
            tick();
        end
        load_check("post_rst_mem", 64'h80, 3'd3, 3'd0, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_model.md
# dcache_model

Data-cache responder for the LSU fire interface: the memory side of the store/load request channels and the driver of the load-response channel. It accepts stores and loads, holds a small zero-initialised word memory, and returns load data tagged with the originating LDQ tag. Loads whose tag is killed by the LSU are squashed in flight and never returned. It is used as the dcache stand-in for LSU-level integration and bring-up.

## Interface
- XLEN, 64, data/address width (64 only).
- LDQ_DEPTH, 8, number of LDQ entries; width of the kill mask.
- LDQ_WIDTH, 3, LDQ tag width, equal to log2(LDQ_DEPTH).
- STQ_WIDTH, 3, STQ tag width.
- MEM_AW, 6, log2 of memory depth in 64-bit words.
- clk in 1 — single clock, rising edge.
- rst in 1 — asynchronous, active-high reset.
- fire_st_addr in XLEN — store byte address.
- fire_st_data in XLEN — store data, right-justified.
- fire_st_data_size in 3 — 0 = B, 1 = H, 2 = W, 3 = D; 4–7 are illegal.
- fire_st_stq_tag in STQ_WIDTH — carried for debug only; no function.
- fire_st_valid in 1 / fire_st_ready out 1 — store handshake.
- fire_ld_addr in XLEN — load byte address.
- fire_ld_data_size in 3 — RISC-V funct3 encoding: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU; 7 is illegal.
- fire_ld_ldq_tag in LDQ_WIDTH — tag returned with the data.
- fire_ld_valid in 1 / fire_ld_ready out 1 — load handshake.
- fire_ld_kill in LDQ_DEPTH — one-hot-per-tag kill mask, sampled every cycle.
- dcache_data out XLEN — load result, already sign- or zero-extended.
- dcache_ldq_tag out LDQ_WIDTH — tag of the result.
- dcache_valid out 1 / dcache_ready in 1 — response handshake.

## Operation
- **Memory:** 2^MEM_AW words of XLEN flops, cleared to 0 by rst.
  - Word index = addr[3 +: MEM_AW]. Higher address bits are ignored, so addresses alias modulo the memory size.
  - Byte offset = addr[2:0] with the bits below the access size forced to 0. Misaligned addresses are aligned down, and no access crosses a word boundary.
- **Store:** on fire_st_valid & fire_st_ready, write only the byte lanes selected by size and offset, at the clock edge.
  - Illegal sizes perform no write, but the handshake still completes.
  - fire_st_ready = 1 whenever rst is low.
- **Load:** on fire_ld_valid & fire_ld_ready, read the word from the current memory contents, i.e. before any same-cycle store.
  - Extract the field selected by size and offset, then sign-extend for sizes 0–3 or zero-extend for sizes 4–6.
  - Size 7 returns 0.
  - The formatted data and tag are pushed into the response buffer.
- **Response buffer:** 2 entries, each holding {valid, tag, data}, kept in age order.
  - Head = oldest valid entry.
  - When a newer entry exists and the head is removed, the newer entry compacts into the head slot.
- **Ready and valid:**
  - fire_ld_ready = rst low and (valid-entry count < 2). It has no combinational dependence on dcache_ready.
  - dcache_valid = head valid & ~fire_ld_kill[head tag] (combinational mask). dcache_data and dcache_ldq_tag always reflect the head.
  - The head pops on dcache_valid & dcache_ready.
- **Kill:** each cycle, every buffered entry whose tag bit is set in fire_ld_kill is invalidated at the edge.
  - A load accepted in the same cycle that its own tag is killed completes its handshake but is not buffered.
- **Simultaneous events:**
  - Pop, kill and push may all occur in one cycle. The result is the surviving old entries in order, followed by the push.
  - Store and load in the same cycle are independent; the load sees the old data.

## Timing
- **Reset values** (rst high, asynchronous): fire_st_ready 0, fire_ld_ready 0, dcache_valid 0, dcache_data 0, dcache_ldq_tag 0, buffer empty, memory 0.
- **Leaving reset:** both ready outputs are 1 in the first cycle with rst low.
- **Load latency:** a load accepted in cycle N gives dcache_valid = 1 in cycle N+1 at the earliest.
- **Throughput:** 1 load per cycle while dcache_ready = 1, because the buffer never exceeds one entry in that case.
- **Backpressure:** with dcache_ready = 0, two loads are accepted and fire_ld_ready drops in the cycle after the second acceptance.
- **Store visibility:** a store written at the edge ending cycle N is visible to loads accepted in cycle N+1 or later.
- **Stability:** dcache_valid, dcache_data and dcache_ldq_tag stay stable while dcache_valid & ~dcache_ready, unless a kill removes the head.
- **Reset mid-operation:** buffered responses are dropped and memory is cleared; no response is emitted after rst.

## Test plan
- **Reset:** assert rst asynchronously mid-cycle with 2 buffered loads → all outputs 0 immediately. After release, both ready outputs are 1 and no dcache_valid ever appears.
- **Store/load formatting:**
  - SD 0x8000_0000_0000_00F0 at addr 0x10, then LB at 0x10 → 0xFFFF_FFFF_FFFF_FFF0 with the issuing tag.
  - LBU at 0x10 → 0xF0.
  - LD at 0x210 with MEM_AW = 6 (aliases to word 2) → full word.
- **Partial store:** SD 0 at 0x8, SH 0xBEEF at 0xA, then LD at 0x8 → 0x0000_0000_BEEF_0000. A same-cycle load to 0x8 alongside the SH returns 0.
- **Backpressure:** hold dcache_ready = 0 and issue loads with tags 1, 2, 3.
  - Tags 1 and 2 are accepted; fire_ld_ready = 0 while tag 3 waits.
  - Raise dcache_ready → responses come out in order 1, 2, 3, with tag 3 accepted once a slot frees.
- **Kill:** buffer tags 4 and 5 with dcache_ready = 0, pulse fire_ld_kill = 0x10 for one cycle → only tag 5 is returned. Issue tag 6 in the same cycle as fire_ld_kill = 0x40 → handshake completes and there is no response.
- **Streaming:** 100 back-to-back loads with dcache_ready = 1 → one response per cycle at latency 1, fire_ld_ready never drops, data matches a reference memory model.
